muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit between the register file read ports and its write port.
- Takes operands from RD1/RD2, holds the core stalled while it runs, and returns a result plus destination index and write enable for WD3/A3/WE3.
- Without it the core cannot execute M-extension instructions.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, FUNCT3 codes and FSM state encoding for the RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift/add for multiply, restoring shift/subtract for divide.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] shreg_i,
   input  logic [XLEN-1:0] operand_i,
   input  logic            isDiv_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] shreg_o
);

   logic [XLEN:0] mulSum;
   logic [XLEN:0] divShift;
   logic          divGeq;

   // Multiply shifts {carry,acc,shreg} right; divide shifts {acc,shreg} left and trial-subtracts.
   always_comb begin
      mulSum   = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
      divShift = {acc_i, shreg_i[XLEN-1]};
      divGeq   = (divShift >= {1'b0, operand_i});
      if (isDiv_i) begin
         acc_o   = divGeq ? (divShift[XLEN-1:0] - operand_i) : divShift[XLEN-1:0];
         shreg_o = {shreg_i[XLEN-2:0], divGeq};
      end else begin
         acc_o   = mulSum[XLEN:1];
         shreg_o = {mulSum[0], shreg_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with registered result/writeback outputs.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiply; divide stays iterative.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] OPA,
   input  logic [XLEN-1:0] OPB,
   input  logic [4:0]      RD_IN,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT,
   output logic            WE_OUT,
   output logic [4:0]      A3_OUT
);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       f3_q;
   logic [XLEN-1:0]  acc_q;
   logic [XLEN-1:0]  shreg_q;
   logic [XLEN-1:0]  opnd_q;
   logic             neg_q;
   logic             busy_q;
   logic             done_q;
   logic             we_q;
   logic [XLEN-1:0]  result_q;
   logic [4:0]       rd_q;

   logic             isDiv_d;
   logic             sgnA_d;
   logic             sgnB_d;
   logic             negA_d;
   logic             negB_d;
   logic [XLEN-1:0]  magA_d;
   logic [XLEN-1:0]  magB_d;
   logic             divZero_d;
   logic             ovf_d;
   logic             special_d;
   logic [XLEN-1:0]  specialRes_d;
   logic             negStart_d;
   logic [XLEN-1:0]  stepAcc_d;
   logic [XLEN-1:0]  stepSh_d;
   logic [2*XLEN-1:0] prod_d;
   logic [2*XLEN-1:0] prodFix_d;
   logic [XLEN-1:0]  fixRes_d;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fastProd_d;
   logic [XLEN-1:0]   fastRes_d;
`endif

   // Operands are reduced to magnitudes at capture; the sign of the final result is kept in neg_q.
   always_comb begin
      isDiv_d      = FUNCT3[2];
      sgnA_d       = isDiv_d ? !FUNCT3[0] : (FUNCT3 == F3_MULH || FUNCT3 == F3_MULHSU);
      sgnB_d       = isDiv_d ? !FUNCT3[0] : (FUNCT3 == F3_MULH);
      negA_d       = sgnA_d & OPA[XLEN-1];
      negB_d       = sgnB_d & OPB[XLEN-1];
      magA_d       = negA_d ? -OPA : OPA;
      magB_d       = negB_d ? -OPB : OPB;
      divZero_d    = isDiv_d && (OPB == '0);
      ovf_d        = isDiv_d && !FUNCT3[0] && (OPA == INT_MIN) && (OPB == DIV0_Q);
      special_d    = divZero_d || ovf_d;
      specialRes_d = divZero_d ? (FUNCT3[1] ? OPA : DIV0_Q) : (FUNCT3[1] ? '0 : INT_MIN);
      negStart_d   = (isDiv_d && FUNCT3[1]) ? negA_d : (negA_d ^ negB_d);
   end

`ifdef MULDIV_FAST_MUL_EN
   always_comb begin
      fastProd_d = {{XLEN{negA_d}}, OPA} * {{XLEN{negB_d}}, OPB};
      fastRes_d  = (FUNCT3 == F3_MUL) ? fastProd_d[XLEN-1:0] : fastProd_d[2*XLEN-1:XLEN];
   end
`endif

   muldiv_step u_step (
      .acc_i     (acc_q),
      .shreg_i   (shreg_q),
      .operand_i (opnd_q),
      .isDiv_i   (f3_q[2]),
      .acc_o     (stepAcc_d),
      .shreg_o   (stepSh_d)
   );

   // After RUN, acc holds the product high half / remainder and shreg the low half / quotient.
   always_comb begin
      prod_d    = {acc_q, shreg_q};
      prodFix_d = neg_q ? -prod_d : prod_d;
      fixRes_d  = '0;
      case (f3_q)
         F3_MUL:                          fixRes_d = prodFix_d[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:    fixRes_d = prodFix_d[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:                 fixRes_d = neg_q ? -shreg_q : shreg_q;
         default:                         fixRes_d = neg_q ? -acc_q : acc_q;
      endcase
   end

   // The IDLE cycle that follows the DONE pulse retires BUSY before a new request can be accepted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         acc_q    <= '0;
         shreg_q  <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (busy_q) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
                  we_q   <= 1'b0;
               end else if (START) begin
                  f3_q    <= FUNCT3;
                  rd_q    <= RD_IN;
                  neg_q   <= negStart_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  opnd_q  <= isDiv_d ? magB_d : magA_d;
                  shreg_q <= isDiv_d ? magA_d : magB_d;
                  acc_q   <= '0;
                  if (special_d) begin
                     acc_q   <= specialRes_d;
                     state_q <= ST_DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!isDiv_d) begin
                     acc_q   <= fastRes_d;
                     state_q <= ST_DONE;
                  end
`endif
                  else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               acc_q   <= stepAcc_d;
               shreg_q <= stepSh_d;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               acc_q   <= fixRes_d;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               result_q <= acc_q;
               done_q   <= 1'b1;
               we_q     <= (rd_q != 5'd0);
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESULT = result_q;
   assign WE_OUT = we_q;
   assign A3_OUT = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic reference.
module tb_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic [2:0]  FUNCT3 = 3'd0;
   logic [31:0] OPA = 32'd0;
   logic [31:0] OPB = 32'd0;
   logic [4:0]  RD_IN = 5'd0;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;
   logic        WE_OUT;
   logic [4:0]  A3_OUT;

   int checkCount = 0;
   int errorCount = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif

   muldiv_unit dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .START  (START),
      .FUNCT3 (FUNCT3),
      .OPA    (OPA),
      .OPB    (OPB),
      .RD_IN  (RD_IN),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .RESULT (RESULT),
      .WE_OUT (WE_OUT),
      .A3_OUT (A3_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference result from RV32M arithmetic rules, using 64-bit integer math.
   function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint     sa;
      longint     sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return MUL_LAT;
      if (b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issues one op once the unit is idle, scrambles the inputs after capture, and checks the writeback.
   // glitchAt >= 0 pulses START with junk operands that many cycles after capture.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] expRes,
                                input int glitchAt, input string tag);
      int          lat;
      int          waitCnt;
      bit          got;
      logic [31:0] res;
      logic        we;
      logic [4:0]  a3;
      waitCnt = 0;
      res     = 32'd0;
      we      = 1'b0;
      a3      = 5'd0;
      @(negedge CLK);
      while (BUSY && waitCnt < 200) begin
         @(negedge CLK);
         waitCnt++;
      end
      if (waitCnt >= 200) checkOutput({tag, "_idleTimeout"}, 1, 0);
      START  = 1'b1;
      FUNCT3 = f3;
      OPA    = a;
      OPB    = b;
      RD_IN  = rd;
      @(posedge CLK);
      #1;
      START  = 1'b0;
      OPA    = $urandom;
      OPB    = $urandom;
      RD_IN  = 5'($urandom);
      FUNCT3 = 3'($urandom);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         START = (lat == glitchAt);
         @(posedge CLK);
         #1;
         lat++;
         if (DONE) begin
            got = 1'b1;
            res = RESULT;
            we  = WE_OUT;
            a3  = A3_OUT;
         end
      end
      START = 1'b0;
      checkOutput({tag, "_done"}, got, 1);
      if (got) begin
         checkOutput({tag, "_result"}, res, expRes);
         checkOutput({tag, "_we"}, we, (rd != 5'd0));
         checkOutput({tag, "_a3"}, a3, rd);
         checkOutput({tag, "_latency"}, lat, expLatency(f3, a, b));
         @(posedge CLK);
         #1;
         checkOutput({tag, "_pulse"}, DONE, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          lat;
      bit          got;
      int          doneSeen;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;

      #12;
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_done", DONE, 0);
      checkOutput("rst_we", WE_OUT, 0);
      checkOutput("rst_result", RESULT, 0);
      checkOutput("rst_a3", A3_OUT, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      $display("[TB] reset during an in-flight DIVU");
      @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'd5; OPA = 32'd100; OPB = 32'd7; RD_IN = 5'd3;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (9) @(posedge CLK);
      #2;
      checkOutput("midrst_busyBefore", BUSY, 1);
      RST_N = 1'b0;
      #1;
      checkOutput("midrst_busy", BUSY, 0);
      checkOutput("midrst_done", DONE, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      doneSeen = 0;
      repeat (60) begin
         @(posedge CLK);
         #1;
         if (DONE) doneSeen++;
      end
      checkOutput("midrst_noDone", doneSeen, 0);

      $display("[TB] directed multiply and divide cases");
      applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'hFFFF_FFFD, -1, "mul");
      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'hFFFF_FFFF, -1, "mulh");
      applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'h0000_0002, -1, "mulhu");
      applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, -1, "mulhsu");
      applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, -1, "div");
      applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, -1, "rem");
      applyStimulus(3'd5, 32'd100, 32'd7, 5'd8, 32'd14, -1, "divu");
      applyStimulus(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, -1, "remu");
      applyStimulus(3'd4, 32'h1234, 32'd0, 5'd9, 32'hFFFF_FFFF, -1, "div0");
      applyStimulus(3'd6, 32'h1234, 32'd0, 5'd9, 32'h0000_1234, -1, "rem0");
      applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, -1, "divOvf");
      applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, -1, "remOvf");

      $display("[TB] START pulsed during RUN, and rd=0");
      applyStimulus(3'd5, 32'd1000, 32'd9, 5'd11, 32'd111, 5, "glitch");
      applyStimulus(3'd0, 32'd12345, 32'd678, 5'd0, 32'd8369910, -1, "rd0");

      $display("[TB] START held high across completion");
      @(negedge CLK);
      while (BUSY) @(negedge CLK);
      START = 1'b1; FUNCT3 = 3'd5; OPA = 32'd100; OPB = 32'd7; RD_IN = 5'd9;
      @(posedge CLK);
      #1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(posedge CLK);
         #1;
         lat++;
         if (DONE) got = 1'b1;
      end
      checkOutput("held_done", got, 1);
      checkOutput("held_result", RESULT, 32'd14);
      FUNCT3 = 3'd5; OPA = 32'd55; OPB = 32'd0;
      @(posedge CLK);
      #1;
      checkOutput("held_idleGap", BUSY, 0);
      @(posedge CLK);
      #1;
      checkOutput("held_capture", BUSY, 1);
      START = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("held_secondDone", DONE, 1);
      checkOutput("held_secondResult", RESULT, 32'hFFFF_FFFF);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         rd = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         applyStimulus(f3, a, b, rd, refModel(f3, a, b), -1, $sformatf("rnd%0d_f%0d", i, f3));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
